// File: rtl/reg_rd_arb.sv
// Register-file read arbiter: grant+issue, then capture; req->rsp_vld is 2 cycles, one grant per cycle, no backpressure.
// Define REG_ARB_RR_EN for round-robin arbitration; otherwise fixed priority with the lowest index winning.
module reg_rd_arb #(
  parameter int REG_SZ = 32,
  parameter int NREQ   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [5*NREQ-1:0] req_idx,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_vld,
  output logic [REG_SZ-1:0] rsp_data,
  output logic              reg_re,
  output logic [4:0]        reg_idx,
  input  logic [REG_SZ-1:0] reg_in,
  input  logic              wb_e,
  input  logic [4:0]        wb_idx,
  input  logic [REG_SZ-1:0] wb_data
);
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]     start;
  logic [IW-1:0]     win;
  logic [4:0]        win_idx;
  logic              any;
  logic [REG_SZ-1:0] cap;

`ifdef REG_ARB_RR_EN
  logic [IW-1:0] ptr;
  assign start = ptr;
`else
  assign start = '0;
`endif

  assign any = |req;

  // Scan from the highest search offset down so the offset closest to start wins.
  always_comb begin
    logic [IW-1:0] j;
    win = '0;
    j   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IW'((int'(start) + k) % NREQ);
      if (req[j]) win = j;
    end
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) win_idx = req_idx[5*i +: 5];
    end
  end

  // reg_idx doubles as the stage-B index; a nonzero match implies wb_idx is nonzero too.
  always_comb begin
    if (reg_idx == 5'd0)                   cap = '0;
    else if (wb_e && (wb_idx == reg_idx))  cap = wb_data;
    else                                   cap = reg_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt      <= '0;
      reg_re   <= 1'b0;
      reg_idx  <= '0;
      rsp_vld  <= '0;
      rsp_data <= '0;
    end else begin
      reg_re  <= any;
      gnt     <= any ? (NREQ'(1) << win) : '0;
      if (any) reg_idx <= win_idx;
      rsp_vld <= gnt;
      if (reg_re) rsp_data <= cap;
    end
  end

`ifdef REG_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
    end
  end
`endif

endmodule
